// File: rtl/ttfir_pkg.sv
// Shared definitions for the tapeout FIR slice host driver: default widths,
// controller states, capture-pipe tag type and slice pin map.
package ttfir_pkg;

  localparam int BW_IN_DEF  = 6;
  localparam int BW_OUT_DEF = 8;

  // Bit positions on the slice io_in bus
  localparam int PIN_CLK   = 0;
  localparam int PIN_RST   = 1;
  localparam int PIN_X_LSB = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST    = 3'd1,
    LOAD   = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  // Tag travelling alongside a sample while the slice computes its result
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  // Number of results still in flight inside the two-stage capture pipe
  function automatic logic [1:0] pipe_occ(input tag_t s1, input tag_t s2);
    return {1'b0, s1.valid} + {1'b0, s2.valid};
  endfunction

endpackage

// File: rtl/ttfir_result_fifo.sv
// First-word fall-through result FIFO. The head entry is read straight from
// the entry registers, so data is visible the cycle after it is pushed.
module ttfir_result_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             pop_fire;
  logic             full;

  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign valid    = (count_reg != '0);
  assign pop_fire = pop && valid;
  assign head     = mem_reg[rd_ptr_reg];
  assign count    = count_reg;

  // One register per entry; cleared on reset so the head reads zero when empty
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (reset) begin
        mem_reg[gi] <= '0;
      end else if (push && (wr_ptr_reg == AW'(gi))) begin
        mem_reg[gi] <= push_data;
      end
    end
  end

  // Pointer and occupancy bookkeeping; push and pop may coincide even when full
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_fire) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop_fire})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // The host throttles input so that a push never lands on a full FIFO unless
  // the head is leaving in the same cycle.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && full && !pop_fire));

endmodule

// File: rtl/ttfir_host.sv
// Host-side driver for the FIR slice: resets it, loads the coefficient,
// streams samples over its pins and returns results in order through a FIFO.
module ttfir_host
  import ttfir_pkg::*;
#(
  parameter int BW_in        = BW_IN_DEF,
  parameter int BW_out       = BW_OUT_DEF,
  parameter int RESET_CYCLES = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BW_in-1:0]  coef_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BW_in-1:0]  in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BW_out-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [7:0]        dut_io_in,
  input  logic [7:0]        dut_io_out
);

  localparam int CW  = $clog2(RESET_CYCLES + 1);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] PIN_RESET_VAL = 8'(1) << PIN_RST;

  state_t            state_reg;
  state_t            state_next;
  logic [CW-1:0]     rst_cnt_reg;
  logic [BW_in-1:0]  coef_reg;
  logic [7:0]        pin_reg;
  logic [7:0]        pin_next;
  logic              rst_pin_next;
  logic [BW_in-1:0]  x_next;
  tag_t              tag1_reg;
  tag_t              tag2_reg;
  logic              accept;
  logic [FAW:0]      fifo_count;
  logic [FAW+1:0]    occ;
  logic [BW_out:0]   fifo_head;
  logic              pipe_empty;

  // Everything already accepted but not yet consumed: queued plus in flight
  assign occ        = (FAW+2)'(fifo_count) + (FAW+2)'(pipe_occ(tag1_reg, tag2_reg));
  assign pipe_empty = !tag1_reg.valid && !tag2_reg.valid;
  assign accept     = in_valid && in_ready;
  assign busy       = (state_reg != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RST;
      RST:     if (rst_cnt_reg == '0) state_next = LOAD;
      LOAD:    state_next = STREAM;
      STREAM:  if (accept && in_last) state_next = DRAIN;
      DRAIN:   if (pipe_empty && (fifo_count == '0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs and next values for the registered slice pins
  always_comb begin
    in_ready     = 1'b0;
    rst_pin_next = pin_reg[PIN_RST];
    x_next       = pin_reg[PIN_X_LSB +: BW_in];
    case (state_reg)
      IDLE: begin
        x_next = '0;
        if (start) rst_pin_next = 1'b1;
      end
      RST: begin
        if (rst_cnt_reg == '0) begin
          // Release reset and present the coefficient for the single LOAD cycle
          rst_pin_next = 1'b0;
          x_next       = coef_reg;
        end else begin
          rst_pin_next = 1'b1;
          x_next       = '0;
        end
      end
      LOAD: begin
        rst_pin_next = 1'b0;
        x_next       = '0;
      end
      STREAM: begin
        rst_pin_next = 1'b0;
        in_ready     = (occ < (FAW+2)'(FIFO_DEPTH));
        if (in_valid && in_ready) x_next = in_data;
      end
      DRAIN: begin
        rst_pin_next = 1'b0;
      end
      default: begin
        rst_pin_next = 1'b1;
        x_next       = '0;
      end
    endcase
  end

  // Assemble the slice pin bus; the clock pin is tied at top level
  for (genvar gi = 0; gi < 8; gi++) begin : g_pin
    if (gi == PIN_RST) begin : g_rst
      assign pin_next[gi] = rst_pin_next;
    end else if ((gi >= PIN_X_LSB) && (gi < PIN_X_LSB + BW_in)) begin : g_x
      assign pin_next[gi] = x_next[gi - PIN_X_LSB];
    end else begin : g_zero
      assign pin_next[gi] = 1'b0;
    end
  end

  // Slice pins are driven from flops so the slice sees clean, edge-aligned inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      pin_reg <= PIN_RESET_VAL;
    end else begin
      pin_reg <= pin_next;
    end
  end

  assign dut_io_in = pin_reg;

  // Coefficient latch and slice-reset down-counter
  always_ff @(posedge clk) begin
    if (reset) begin
      coef_reg    <= '0;
      rst_cnt_reg <= '0;
    end else if ((state_reg == IDLE) && start) begin
      coef_reg    <= coef_in;
      rst_cnt_reg <= CW'(RESET_CYCLES - 1);
    end else if ((state_reg == RST) && (rst_cnt_reg != '0)) begin
      rst_cnt_reg <= rst_cnt_reg - CW'(1);
    end
  end

  // Capture pipe: a tag enters on accept and reaches stage 2 exactly when the
  // slice output for that sample is on dut_io_out
  always_ff @(posedge clk) begin
    if (reset) begin
      tag1_reg <= '0;
      tag2_reg <= '0;
    end else begin
      tag1_reg <= accept ? tag_t'{valid: 1'b1, last: in_last} : tag_t'('0);
      tag2_reg <= tag1_reg;
    end
  end

  ttfir_result_fifo #(
    .WIDTH (BW_out + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tag2_reg.valid),
    .push_data ({tag2_reg.last, dut_io_out[BW_out-1:0]}),
    .pop       (out_ready),
    .valid     (out_valid),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign out_data = fifo_head[BW_out-1:0];
  assign out_last = fifo_head[BW_out];

endmodule

// File: tb/tb_ttfir_host.sv
// Bench for ttfir_host with a behavioural model of the FIR slice on its pins.
module tb_ttfir_host;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] coef_in = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic [7:0] dut_io_in;
  logic [7:0] dut_io_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int         acc_q[$];
  logic [7:0] got_d[$];
  logic       got_l[$];
  int         got_c[$];

  always #5 clk = ~clk;

  ttfir_host #(
    .BW_in        (6),
    .BW_out       (8),
    .RESET_CYCLES (3),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .coef_in    (coef_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .dut_io_in  (dut_io_in),
    .dut_io_out (dut_io_out)
  );

  // Slice model: reset pin clears it, first non-reset edge latches the
  // coefficient, every later edge registers x - coef.
  logic       sl_loaded = 1'b0;
  logic [5:0] sl_coef = '0;
  logic [7:0] sl_out = '0;
  assign dut_io_out = sl_out;

  function automatic logic [7:0] sx(input logic [5:0] v);
    return {{2{v[5]}}, v};
  endfunction

  always @(posedge clk) begin
    if (dut_io_in[1]) begin
      sl_loaded <= 1'b0;
      sl_coef   <= '0;
      sl_out    <= '0;
    end else if (!sl_loaded) begin
      sl_coef   <= dut_io_in[7:2];
      sl_loaded <= 1'b1;
    end else begin
      sl_out <= sx(dut_io_in[7:2]) - sx(sl_coef);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Record handshakes half a cycle before the edge that completes them
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
        got_c.push_back(cyc);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic expect_res(input string nm, input int idx, input logic [7:0] d, input logic l);
    if (idx < got_d.size()) begin
      chk({nm, "_data"}, {24'b0, got_d[idx]}, {24'b0, d});
      chk({nm, "_last"}, {31'b0, got_l[idx]}, {31'b0, l});
    end else begin
      chk({nm, "_missing"}, got_d.size(), idx + 1);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", {31'b0, busy}, 0);
  endtask

  task automatic start_job(input logic [5:0] c);
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("start_timeout", {31'b0, busy}, 0);
    @(posedge clk); #1;
    start = 1'b1;
    coef_in = c;
    @(posedge clk); #1;
    start = 1'b0;
    coef_in = '0;
  endtask

  task automatic send(input logic [5:0] x, input logic l);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = x;
    in_last = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", {31'b0, in_ready}, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
  endtask

  typedef struct {
    logic [5:0] coef;
    logic [5:0] x;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ab, gb, n;
    logic       pv[5];
    logic [5:0] pd[5];

    vecs[0] = '{6'h05, 6'h07, 8'h02};
    vecs[1] = '{6'h1F, 6'h20, 8'hC1};
    vecs[2] = '{6'h20, 6'h1F, 8'h3F};
    vecs[3] = '{6'h00, 6'h00, 8'h00};
    vecs[4] = '{6'h3F, 6'h3F, 8'h00};
    vecs[5] = '{6'h0A, 6'h2C, 8'hE2};
    vecs[6] = '{6'h00, 6'h1F, 8'h1F};
    vecs[7] = '{6'h01, 6'h20, 8'hDF};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_pins", {24'b0, dut_io_in}, 32'h02);
    chk("rst_out_data", {24'b0, out_data}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic three-sample job
    ab = acc_q.size();
    gb = got_d.size();
    start_job(6'h05);
    send(6'h07, 1'b0);
    send(6'h3D, 1'b0);
    send(6'h00, 1'b1);
    wait_idle();
    chk("basic_count", got_d.size() - gb, 3);
    expect_res("basic0", gb, 8'h02, 1'b0);
    expect_res("basic1", gb + 1, 8'hF8, 1'b0);
    expect_res("basic2", gb + 2, 8'hFB, 1'b1);
    if (got_c.size() > gb && acc_q.size() > ab)
      chk("basic_latency", got_c[gb] - acc_q[ab], 3);

    // Single-sample jobs from the vector table, including wrap cases
    for (int i = 0; i < 8; i++) begin
      gb = got_d.size();
      start_job(vecs[i].coef);
      send(vecs[i].x, 1'b1);
      wait_idle();
      chk($sformatf("vec%0d_count", i), got_d.size() - gb, 1);
      expect_res($sformatf("vec%0d", i), gb, vecs[i].exp, 1'b1);
    end

    // Backpressure: six samples offered with out_ready low
    out_ready = 1'b0;
    ab = acc_q.size();
    gb = got_d.size();
    start_job(6'h02);
    fork
      begin
        for (int i = 0; i < 6; i++) send(6'(i + 1), (i == 5));
      end
      begin
        repeat (25) @(negedge clk);
        chk("bp_accepted", acc_q.size() - ab, 4);
        chk("bp_in_ready", {31'b0, in_ready}, 0);
        chk("bp_out_valid", {31'b0, out_valid}, 1);
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("bp_stable%0d", k), {24'b0, out_data}, 32'hFF);
          @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_idle();
    chk("bp_count", got_d.size() - gb, 6);
    for (int i = 0; i < 6; i++)
      expect_res($sformatf("bp%0d", i), gb + i, 8'(i - 1), (i == 5));

    // Gapped input: in_valid 1,0,0,1,1 with junk data on idle cycles
    pv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    pd = '{6'h0A, 6'h15, 6'h15, 6'h14, 6'h36};
    ab = acc_q.size();
    gb = got_d.size();
    start_job(6'h3C);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("gap_stream_ready", {31'b0, in_ready}, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = pv[i];
      in_data = pd[i];
      in_last = (i == 4);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    wait_idle();
    chk("gap_accepted", acc_q.size() - ab, 3);
    chk("gap_count", got_d.size() - gb, 3);
    expect_res("gap0", gb, 8'h0E, 1'b0);
    expect_res("gap1", gb + 1, 8'h18, 1'b0);
    expect_res("gap2", gb + 2, 8'hFA, 1'b1);

    // Start handling: reset pin width, coefficient on pins, ignored second start
    gb = got_d.size();
    start_job(6'h0D);
    n = 0;
    @(negedge clk);
    while (dut_io_in[1] && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("st_rst_cycles", n, 3);
    chk("st_coef_pins", {26'b0, dut_io_in[7:2]}, 32'h0D);
    chk("st_clk_pin", {31'b0, dut_io_in[0]}, 0);
    @(posedge clk); #1;
    start = 1'b1;
    coef_in = 6'h01;
    @(posedge clk); #1;
    start = 1'b0;
    coef_in = '0;
    chk("st_busy", {31'b0, busy}, 1);
    send(6'h14, 1'b1);
    wait_idle();
    chk("st_count", got_d.size() - gb, 1);
    expect_res("st_res", gb, 8'h07, 1'b1);

    // Reset in the middle of STREAM with two results queued
    out_ready = 1'b0;
    start_job(6'h02);
    send(6'h01, 1'b0);
    send(6'h02, 1'b0);
    repeat (4) @(negedge clk);
    chk("mr_pre_valid", {31'b0, out_valid}, 1);
    chk("mr_pre_count", {29'b0, dut.fifo_count}, 2);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mr_out_valid", {31'b0, out_valid}, 0);
    chk("mr_busy", {31'b0, busy}, 0);
    chk("mr_in_ready", {31'b0, in_ready}, 0);
    chk("mr_pins", {24'b0, dut_io_in}, 32'h02);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    gb = got_d.size();
    start_job(6'h03);
    send(6'h04, 1'b0);
    send(6'h3C, 1'b1);
    wait_idle();
    chk("mr_count", got_d.size() - gb, 2);
    expect_res("mr0", gb, 8'h01, 1'b0);
    expect_res("mr1", gb + 1, 8'hF9, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
